// File: rtl/bus_xfer_ctrl.sv
// Registered shared-bus transfer controller: one-hot source select, counter, conflict latch.
// Build with BUS_CONFLICT_CHECK_EN to enable multi-driver detection and the FAULT state.
module bus_xfer_ctrl #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  input  logic [N_SRC-1:0]         src_out,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [$clog2(N_SRC)-1:0] sel_idx,
  output logic                     conflict,
  output logic [CNT_W-1:0]         xfer_cnt
);

  localparam int IdxW = $clog2(N_SRC);

`ifdef BUS_CONFLICT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FAULT
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [IdxW-1:0] drvIdx;
  logic [WIDTH-1:0] drvWord;
  logic            anyDrv;
  logic            multiDrv;
  logic            accept;

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    drvIdx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) drvIdx = IdxW'(i);
    end
  end

  assign anyDrv   = |src_out;
  assign multiDrv = |(src_out & (src_out - N_SRC'(1)));
  assign drvWord  = src_data[int'(drvIdx)*WIDTH +: WIDTH];

  always_comb begin
    nextState = state;
    if (state == FAULT) begin
      // A fresh conflict alongside the clear keeps the fault latched.
      if (err_clr && !(CheckEn && multiDrv)) nextState = IDLE;
    end else begin
      unique case (1'b1)
        !anyDrv:             nextState = IDLE;
        CheckEn && multiDrv: nextState = FAULT;
        default:             nextState = DRIVE;
      endcase
    end
  end

  assign accept = (state != FAULT) && (nextState == DRIVE);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      sel_idx   <= '0;
      xfer_cnt  <= '0;
    end else begin
      state     <= nextState;
      bus_valid <= accept;
      if (accept) begin
        bus_out  <= drvWord;
        sel_idx  <= drvIdx;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BUS_CONFLICT_CHECK_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conflict <= 1'b0;
    end else if (state != FAULT && nextState == FAULT) begin
      conflict <= 1'b1;
    end else if (state == FAULT && nextState == IDLE) begin
      conflict <= 1'b0;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_bus_xfer_ctrl;

  localparam int W = 32;
  localparam int N = 24;
  localparam int C = 16;

`ifdef BUS_CONFLICT_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           clearN;
  logic [N*W-1:0] srcData;
  logic [N-1:0]   srcOut;
  logic           errClr;
  logic [W-1:0]   busOut;
  logic           busValid;
  logic [4:0]     selIdx;
  logic           conflict;
  logic [C-1:0]   xferCnt;

  int compared = 0;
  int mismatched = 0;

  bus_xfer_ctrl #(.WIDTH(W), .N_SRC(N), .CNT_W(C)) dut (
    .clock    (clock),
    .clear_n  (clearN),
    .src_data (srcData),
    .src_out  (srcOut),
    .err_clr  (errClr),
    .bus_out  (busOut),
    .bus_valid(busValid),
    .sel_idx  (selIdx),
    .conflict (conflict),
    .xfer_cnt (xferCnt)
  );

  always #5 clock = ~clock;

  // Reference model: outputs plus a single "faulted" flag.
  logic [W-1:0] mBus;
  logic         mValid;
  logic [4:0]   mSel;
  logic         mConf;
  logic [C-1:0] mCnt;
  logic         mFault;

  typedef struct {
    logic [N-1:0] src;
    logic         err;
    logic [W-1:0] expBus;
    logic         expValid;
    logic [4:0]   expSel;
    logic         expConf;
    logic [C-1:0] expCnt;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [W-1:0] wordOf(int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 + W'(i));
  endfunction

  function automatic int lowIdx(logic [N-1:0] s);
    for (int i = 0; i < N; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBus = '0; mValid = 0; mSel = '0; mConf = 0; mCnt = '0; mFault = 0;
  endtask

  task automatic modelStep();
    int n;
    int lo;
    n = $countones(srcOut);
    lo = lowIdx(srcOut);
    if (mFault) begin
      mValid = 0;
      if (errClr && !(Chk && n > 1)) begin
        mFault = 0;
        mConf = 0;
      end
    end else if (n == 0) begin
      mValid = 0;
    end else if (Chk && n > 1) begin
      mFault = 1;
      mConf = 1;
      mValid = 0;
    end else begin
      mBus = srcData[lo*W +: W];
      mSel = 5'(lo);
      mValid = 1;
      mCnt = mCnt + 1'b1;
    end
  endtask

  task automatic checkModel(string tag);
    chk({tag, ".bus"},   64'(busOut),   64'(mBus));
    chk({tag, ".valid"}, 64'(busValid), 64'(mValid));
    chk({tag, ".sel"},   64'(selIdx),   64'(mSel));
    chk({tag, ".conf"},  64'(conflict), 64'(mConf));
    chk({tag, ".cnt"},   64'(xferCnt),  64'(mCnt));
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic applyReset();
    @(negedge clock);
    clearN = 0;
    #2;
    modelReset();
    chk("rst.bus",   64'(busOut),   64'd0);
    chk("rst.valid", 64'(busValid), 64'd0);
    chk("rst.sel",   64'(selIdx),   64'd0);
    chk("rst.conf",  64'(conflict), 64'd0);
    chk("rst.cnt",   64'(xferCnt),  64'd0);
    @(negedge clock);
    clearN = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic loadFixedWords();
    for (int i = 0; i < N; i++) srcData[i*W +: W] = wordOf(i);
  endtask

  function automatic logic [N-1:0] randSrc();
    int k;
    int a;
    int b;
    logic [N-1:0] s;
    k = $urandom_range(0, 9);
    s = '0;
    if (k < 3) return s;
    a = $urandom_range(0, N - 1);
    s[a] = 1'b1;
    if (k < 7) return s;
    b = (a + $urandom_range(1, N - 1)) % N;
    s[b] = 1'b1;
    if (k == 9) s = s | N'($urandom);
    return s;
  endfunction

  initial begin
    clearN = 1;
    srcOut = '0;
    errClr = 0;
    srcData = '0;

    vecs[0] = '{24'h000020, 1'b0, 32'hDEADBEEF, 1'b1, 5'd5,  1'b0, 16'd1};
    vecs[1] = '{24'h000000, 1'b0, 32'hDEADBEEF, 1'b0, 5'd5,  1'b0, 16'd1};
    vecs[2] = '{24'h000001, 1'b0, 32'hC0DE0000, 1'b1, 5'd0,  1'b0, 16'd2};
    vecs[3] = '{24'h800000, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b0, 16'd3};
    vecs[4] = '{24'h001000, 1'b0, 32'hC0DE000C, 1'b1, 5'd12, 1'b0, 16'd4};
    vecs[5] = '{24'h000000, 1'b0, 32'hC0DE000C, 1'b0, 5'd12, 1'b0, 16'd4};
    vecs[6] = '{24'h000000, 1'b1, 32'hC0DE000C, 1'b0, 5'd12, 1'b0, 16'd4};
    if (Chk) begin
      vecs[7]  = '{24'h000011, 1'b0, 32'hC0DE000C, 1'b0, 5'd12, 1'b1, 16'd4};
      vecs[8]  = '{24'h000008, 1'b0, 32'hC0DE000C, 1'b0, 5'd12, 1'b1, 16'd4};
      vecs[9]  = '{24'h000011, 1'b1, 32'hC0DE000C, 1'b0, 5'd12, 1'b1, 16'd4};
      vecs[10] = '{24'h000008, 1'b1, 32'hC0DE000C, 1'b0, 5'd12, 1'b0, 16'd4};
      vecs[11] = '{24'h000004, 1'b0, 32'hC0DE0002, 1'b1, 5'd2,  1'b0, 16'd5};
    end else begin
      vecs[7]  = '{24'h000011, 1'b0, 32'hC0DE0000, 1'b1, 5'd0,  1'b0, 16'd5};
      vecs[8]  = '{24'h000008, 1'b0, 32'hC0DE0003, 1'b1, 5'd3,  1'b0, 16'd6};
      vecs[9]  = '{24'h000011, 1'b1, 32'hC0DE0000, 1'b1, 5'd0,  1'b0, 16'd7};
      vecs[10] = '{24'h000008, 1'b1, 32'hC0DE0003, 1'b1, 5'd3,  1'b0, 16'd8};
      vecs[11] = '{24'h000004, 1'b0, 32'hC0DE0002, 1'b1, 5'd2,  1'b0, 16'd9};
    end

    loadFixedWords();
    applyReset();

    for (int r = 0; r < 12; r++) begin
      srcOut = vecs[r].src;
      errClr = vecs[r].err;
      tick();
      chk($sformatf("vec%0d.bus", r),   64'(busOut),   64'(vecs[r].expBus));
      chk($sformatf("vec%0d.valid", r), 64'(busValid), 64'(vecs[r].expValid));
      chk($sformatf("vec%0d.sel", r),   64'(selIdx),   64'(vecs[r].expSel));
      chk($sformatf("vec%0d.conf", r),  64'(conflict), 64'(vecs[r].expConf));
      chk($sformatf("vec%0d.cnt", r),   64'(xferCnt),  64'(vecs[r].expCnt));
    end
    srcOut = '0;
    errClr = 0;

    // Asynchronous reset in the middle of a driven cycle.
    srcOut = 24'h000080;
    tick();
    chk("pre_areset.valid", 64'(busValid), 64'd1);
    chk("pre_areset.bus",   64'(busOut),   64'(wordOf(7)));
    #2;
    clearN = 0;
    #1;
    modelReset();
    chk("areset.bus",   64'(busOut),   64'd0);
    chk("areset.valid", 64'(busValid), 64'd0);
    chk("areset.sel",   64'(selIdx),   64'd0);
    chk("areset.conf",  64'(conflict), 64'd0);
    chk("areset.cnt",   64'(xferCnt),  64'd0);
    srcOut = '0;
    @(negedge clock);
    clearN = 1;

    // Randomized traffic against the model.
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) srcData[i*W +: W] = $urandom;
      srcOut = randSrc();
      errClr = ($urandom_range(0, 3) == 0);
      tick();
      checkModel("rand");
    end
    srcOut = '0;
    errClr = 0;

    // Transfer counter wrap.
    applyReset();
    loadFixedWords();
    for (int c = 0; c < 65535; c++) begin
      srcOut = N'(1) << (c % N);
      tick();
    end
    chk("wrap.full", 64'(xferCnt), 64'hFFFF);
    srcOut = 24'h000200;
    tick();
    chk("wrap.zero",  64'(xferCnt),  64'd0);
    chk("wrap.valid", 64'(busValid), 64'd1);
    chk("wrap.bus",   64'(busOut),   64'(wordOf(9)));
    checkModel("wrap");
    srcOut = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
